// File: rtl/axi_ic_pkg.sv
// Shared types and widths for the AXI interconnect arbiters (write and read side).
package axi_ic_pkg;

    localparam int unsigned AXI_LEN_W  = 8;
    localparam int unsigned BEAT_CNT_W = 9;

    typedef enum logic [1:0] {
        W_IDLE,
        W_BURST,
        W_RESP
    } warb_state_t;

endpackage

// File: rtl/axi_write_arbiter_if.sv
// Handshake and grant bundle seen by the write-path arbiter.
//   m0_AWVALID/m1_AWVALID : raw write requests from the two masters
//   s_AWVALID, m_AWREADY, s_AWLEN : muxed AW handshake and burst length
//   s_WVALID, s_WLAST, m_WREADY   : muxed W handshake
//   m_BVALID, s_BREADY            : muxed B handshake
//   m0_wgrnt, m1_wgrnt, wbusy, wlen_err : arbiter outputs
// slave modport: the arbiter. master modport: whatever drives the bus side.
interface axi_write_arbiter_if;
    import axi_ic_pkg::*;

    logic                 m0_AWVALID;
    logic                 m1_AWVALID;
    logic                 s_AWVALID;
    logic                 m_AWREADY;
    logic [AXI_LEN_W-1:0] s_AWLEN;
    logic                 s_WVALID;
    logic                 s_WLAST;
    logic                 m_WREADY;
    logic                 m_BVALID;
    logic                 s_BREADY;
    logic                 m0_wgrnt;
    logic                 m1_wgrnt;
    logic                 wbusy;
    logic                 wlen_err;

    modport slave (
        input  m0_AWVALID, m1_AWVALID,
        input  s_AWVALID, m_AWREADY, s_AWLEN,
        input  s_WVALID, s_WLAST, m_WREADY,
        input  m_BVALID, s_BREADY,
        output m0_wgrnt, m1_wgrnt, wbusy, wlen_err
    );

    modport master (
        output m0_AWVALID, m1_AWVALID,
        output s_AWVALID, m_AWREADY, s_AWLEN,
        output s_WVALID, s_WLAST, m_WREADY,
        output m_BVALID, s_BREADY,
        input  m0_wgrnt, m1_wgrnt, wbusy, wlen_err
    );

endinterface

// File: rtl/axi_write_arbiter.sv
// Two-master arbiter/sequencer for the shared AXI4 write path.
// Grants one master from AW request through the B handshake, inserts one idle
// cycle between grants, and pulses wlen_err when the W beat count of a burst
// differs from AWLEN+1.
// Ports:
//   ACLK   : clock
//   ARESET : synchronous active-high reset
//   bus    : axi_write_arbiter_if.slave (requests, muxed handshakes, grants)
module axi_write_arbiter
    import axi_ic_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1,
    parameter bit FIRST_PRIO  = 1'b0
) (
    input logic               ACLK,
    input logic               ARESET,
    axi_write_arbiter_if.slave bus
);

    // Winner index (0 = m0, 1 = m1) among the current requesters.
    function automatic logic pick_owner(input logic req0, input logic req1, input logic last);
        logic win;
        win = 1'b0;
        if (req0 && req1) begin
            win = ROUND_ROBIN ? ~last : 1'b0;
        end else if (req1) begin
            win = 1'b1;
        end
        return win;
    endfunction

    warb_state_t           state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_owner_q, last_owner_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [AXI_LEN_W-1:0]  len_q, len_d;
    logic                  m0_grnt_q, m0_grnt_d;
    logic                  m1_grnt_q, m1_grnt_d;
    logic                  wbusy_q, wbusy_d;
    logic                  wlen_err_q, wlen_err_d;

    logic                  aw_fire;
    logic                  w_fire;
    logic                  b_fire;
    logic                  win;
    logic [BEAT_CNT_W-1:0] beat_inc;

    assign aw_fire  = bus.s_AWVALID & bus.m_AWREADY;
    assign w_fire   = bus.s_WVALID & bus.m_WREADY;
    assign b_fire   = bus.m_BVALID & bus.s_BREADY;
    assign win      = pick_owner(bus.m0_AWVALID, bus.m1_AWVALID, last_owner_q);
    // Beat counter saturates rather than wrapping on runaway bursts.
    assign beat_inc = (beat_cnt_q == {BEAT_CNT_W{1'b1}}) ? beat_cnt_q
                                                         : beat_cnt_q + BEAT_CNT_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        beat_cnt_d   = beat_cnt_q;
        len_d        = len_q;
        m0_grnt_d    = m0_grnt_q;
        m1_grnt_d    = m1_grnt_q;
        wlen_err_d   = 1'b0;

        unique case (state_q)
            W_IDLE: begin
                m0_grnt_d = 1'b0;
                m1_grnt_d = 1'b0;
                if (bus.m0_AWVALID || bus.m1_AWVALID) begin
                    state_d    = W_BURST;
                    owner_d    = win;
                    m0_grnt_d  = ~win;
                    m1_grnt_d  = win;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    beat_cnt_d = '0;
                end
            end

            W_BURST: begin
                if (aw_fire && !aw_done_q) begin
                    len_d     = bus.s_AWLEN;
                    aw_done_d = 1'b1;
                end
                // Beats after WLAST are not counted; the final count stays frozen.
                if (w_fire && !w_done_q) begin
                    beat_cnt_d = beat_inc;
                    if (bus.s_WLAST) begin
                        w_done_d = 1'b1;
                    end
                end
                if (aw_done_d && w_done_d) begin
                    state_d    = W_RESP;
                    wlen_err_d = (beat_cnt_d != (BEAT_CNT_W'(len_d) + BEAT_CNT_W'(1)));
                end
            end

            W_RESP: begin
                if (b_fire) begin
                    state_d      = W_IDLE;
                    last_owner_d = owner_q;
                    m0_grnt_d    = 1'b0;
                    m1_grnt_d    = 1'b0;
                end
            end

            default: begin
                state_d   = W_IDLE;
                m0_grnt_d = 1'b0;
                m1_grnt_d = 1'b0;
            end
        endcase

        wbusy_d = m0_grnt_d | m1_grnt_d;
    end

    // State and output registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= W_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= ~FIRST_PRIO;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            beat_cnt_q   <= '0;
            len_q        <= '0;
            m0_grnt_q    <= 1'b0;
            m1_grnt_q    <= 1'b0;
            wbusy_q      <= 1'b0;
            wlen_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            beat_cnt_q   <= beat_cnt_d;
            len_q        <= len_d;
            m0_grnt_q    <= m0_grnt_d;
            m1_grnt_q    <= m1_grnt_d;
            wbusy_q      <= wbusy_d;
            wlen_err_q   <= wlen_err_d;
        end
    end

    assign bus.m0_wgrnt = m0_grnt_q;
    assign bus.m1_wgrnt = m1_grnt_q;
    assign bus.wbusy    = wbusy_q;
    assign bus.wlen_err = wlen_err_q;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Testbench: a round-robin and a fixed-priority arbiter see identical bus
// stimulus; each is checked against its own transaction-level expectations.
module tb_axi_write_arbiter;
    import axi_ic_pkg::*;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    logic       m0_req = 1'b0, m1_req = 1'b0;
    logic       awv = 1'b0, awr = 1'b0, wv = 1'b0, wl = 1'b0, wr = 1'b0, bv = 1'b0, br = 1'b0;
    logic [7:0] awlen = 8'd0;

    axi_write_arbiter_if ifa();
    axi_write_arbiter_if ifb();

    assign ifa.m0_AWVALID = m0_req; assign ifb.m0_AWVALID = m0_req;
    assign ifa.m1_AWVALID = m1_req; assign ifb.m1_AWVALID = m1_req;
    assign ifa.s_AWVALID  = awv;    assign ifb.s_AWVALID  = awv;
    assign ifa.m_AWREADY  = awr;    assign ifb.m_AWREADY  = awr;
    assign ifa.s_AWLEN    = awlen;  assign ifb.s_AWLEN    = awlen;
    assign ifa.s_WVALID   = wv;     assign ifb.s_WVALID   = wv;
    assign ifa.s_WLAST    = wl;     assign ifb.s_WLAST    = wl;
    assign ifa.m_WREADY   = wr;     assign ifb.m_WREADY   = wr;
    assign ifa.m_BVALID   = bv;     assign ifb.m_BVALID   = bv;
    assign ifa.s_BREADY   = br;     assign ifb.s_BREADY   = br;

    axi_write_arbiter #(.ROUND_ROBIN(1'b1), .FIRST_PRIO(1'b0)) dut_a (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (ifa)
    );

    axi_write_arbiter #(.ROUND_ROBIN(1'b0), .FIRST_PRIO(1'b0)) dut_b (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (ifb)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Expected grant holder per DUT: 0 none, 1 m0, 2 m1.
    int ga = 0, gb = 0;
    // Last completed owner per DUT (0 = m0, 1 = m1).
    int last_a = 1, last_b = 1;
    // Owner grant history for DUT A, for the order check.
    int order_a[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arbitration rule: single requester wins; on a tie RR alternates, fixed picks m0.
    function automatic int pick(input bit r0, input bit r1, input int last, input bit rr);
        if (r0 && r1) return rr ? (1 - last) : 0;
        if (r1) return 1;
        return 0;
    endfunction

    // One clock, then compare every output of both DUTs.
    task automatic step(input bit err_exp);
        @(posedge ACLK);
        #1;
        chk("a_m0_wgrnt", 32'(ifa.m0_wgrnt), 32'(ga == 1));
        chk("a_m1_wgrnt", 32'(ifa.m1_wgrnt), 32'(ga == 2));
        chk("a_wbusy",    32'(ifa.wbusy),    32'(ga != 0));
        chk("a_wlen_err", 32'(ifa.wlen_err), 32'(err_exp));
        chk("b_m0_wgrnt", 32'(ifb.m0_wgrnt), 32'(gb == 1));
        chk("b_m1_wgrnt", 32'(ifb.m1_wgrnt), 32'(gb == 2));
        chk("b_wbusy",    32'(ifb.wbusy),    32'(gb != 0));
        chk("b_wlen_err", 32'(ifb.wlen_err), 32'(err_exp));
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        m0_req = 0; m1_req = 0; awv = 0; awr = 0; wv = 0; wl = 0; wr = 0; bv = 0; br = 0;
        ga = 0; gb = 0;
        last_a = 1; last_b = 1;
        step(1'b0);
        step(1'b0);
        ARESET = 1'b0;
        step(1'b0);
    endtask

    // One write transaction. aw_at < 0: AW offered only after WLAST fired;
    // otherwise AW offered from cycle aw_at of the burst phase onward.
    task automatic run_txn(input bit r0, input bit r1, input int len, input int nbeats,
                           input int aw_at, input bit stall, input bit finish_b);
        int  oa, ob, beats, c;
        bit  aw_done, w_done, n_aw, n_wd, err;
        int  n_beats;
        m0_req = r0;
        m1_req = r1;
        oa = pick(r0, r1, last_a, 1'b1);
        ob = pick(r0, r1, last_b, 1'b0);
        ga = oa + 1;
        gb = ob + 1;
        order_a.push_back(oa);
        step(1'b0);

        aw_done = 0; w_done = 0; beats = 0; c = 0;
        awlen = 8'(len);
        awr = 1'b1;
        wr  = 1'b1;
        while (!(aw_done && w_done) && c < 2000) begin
            awv = !aw_done && ((aw_at < 0) ? w_done : (c >= aw_at));
            wv  = !w_done && (!stall || $urandom_range(0, 3) != 0);
            wl  = wv && (beats == nbeats - 1);
            n_aw    = aw_done || awv;
            n_beats = beats + (wv ? 1 : 0);
            n_wd    = w_done || (wv && wl);
            err     = n_aw && n_wd && (n_beats != len + 1);
            step(err);
            aw_done = n_aw; beats = n_beats; w_done = n_wd;
            c++;
        end
        chk("burst_done", 32'(aw_done && w_done), 32'd1);
        awv = 0; wv = 0; wl = 0;
        if (!finish_b) return;

        repeat ($urandom_range(0, 2)) step(1'b0);
        bv = 1'b1;
        br = 1'b1;
        last_a = oa;
        last_b = ob;
        ga = 0;
        gb = 0;
        step(1'b0);
        bv = 0;
        br = 0;
    endtask

    initial begin
        int len, nb, at;
        bit r0, r1;

        // Reset values.
        do_reset();

        // m0 alone: AWLEN=3, four beats, AW first.
        run_txn(1, 0, 3, 4, 0, 0, 1);
        chk("last_owner_after_m0", 32'(last_a), 32'd0);

        // Both requesting, single-beat bursts from reset: RR order m0,m1,m0,m1.
        do_reset();
        order_a.delete();
        repeat (4) run_txn(1, 1, 0, 1, 0, 0, 1);
        chk("rr_order0", 32'(order_a[0]), 32'd0);
        chk("rr_order1", 32'(order_a[1]), 32'd1);
        chk("rr_order2", 32'(order_a[2]), 32'd0);
        chk("rr_order3", 32'(order_a[3]), 32'd1);

        // Only m1 requesting: fixed priority still grants m1.
        run_txn(0, 1, 0, 1, 0, 0, 1);

        // W before AW: two beats then AW with AWLEN=1.
        run_txn(1, 0, 1, 2, -1, 0, 1);

        // AW and last W on the same edge.
        run_txn(0, 1, 2, 3, 2, 0, 1);

        // Length mismatch: AWLEN=3, WLAST on beat 2.
        run_txn(1, 1, 3, 2, 0, 0, 1);

        // Longest legal burst exercises the 9-bit length compare.
        run_txn(1, 0, 255, 256, 0, 0, 1);
        run_txn(0, 1, 255, 255, 0, 0, 1);

        // Randomized transactions.
        repeat (30) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1;
            len = $urandom_range(0, 7);
            nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : len + 1;
            at  = $urandom_range(0, nb + 1) - 1;
            run_txn(r0, r1, len, nb, at, 1'($urandom_range(0, 1)), 1);
        end

        // Reset while DUT A sits in RESP with m1 owning.
        do_reset();
        run_txn(1, 1, 0, 1, 0, 0, 1);
        run_txn(1, 1, 0, 1, 0, 0, 0);
        chk("a_m1_owns_resp", 32'(ifa.m1_wgrnt), 32'd1);
        do_reset();
        run_txn(1, 1, 1, 2, 0, 0, 1);
        chk("after_reset_owner", 32'(last_a), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
